hir_input_stager: RTL and testbench

Upstream feeder for the HIR-generated `Add` kernel. It accepts operand pairs over a valid/ready stream and writes them into two internal 32-bit banks. It then pulses the kernel start input `t3` and serves the kernel's two read ports (`v_addr0/v_rd_en0/v_rd_data0`, `v_addr1/v_rd_en1/v_rd_data1`) with one-cycle read latency. The kernel's completion is reported back through `kernel_done`.

---
 rtl/hir_input_stager.sv | 169 ++++++++++++++++
 tb/tb_hir_input_stager.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hir_input_stager.sv
// rtl/hir_input_stager.sv - operand stager feeding the HIR Add kernel
//
// Purpose: accepts a load command and a stream of operand pairs, stores them
// in two banks, pulses the kernel start (t3) and serves the kernel's two read
// ports with one-cycle latency until kernel_done returns the block to IDLE.
//
// Optional feature macro: HIR_STAGER_RDCHK_EN (builds the sticky rd_err check;
// when undefined rd_err is tied to 0).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_len   load command handshake and pair count
//   in_valid/in_ready/in_a/in_b   operand pair stream (a -> bank0, b -> bank1)
//   t3                            one-cycle kernel start pulse
//   kernel_done                   kernel completion pulse (honoured in RUN)
//   busy                          high whenever not IDLE
//   v_addr0/v_rd_en0/v_rd_data0   bank0 read port
//   v_addr1/v_rd_en1/v_rd_data1   bank1 read port
//   rd_err                        sticky out-of-range read flag
module hir_input_stager #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              t3,
  input  logic              kernel_done,
  output logic              busy,
  input  logic [ADDR_W-1:0] v_addr0,
  input  logic              v_rd_en0,
  output logic [DATA_W-1:0] v_rd_data0,
  input  logic [ADDR_W-1:0] v_addr1,
  input  logic              v_rd_en1,
  output logic [DATA_W-1:0] v_rd_data1,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_wptr;
  logic [DATA_W-1:0] r_bank0 [DEPTH];
  logic [DATA_W-1:0] r_bank1 [DEPTH];

  logic [ADDR_W:0]   w_len_sat;
  logic              w_accept;
  logic              w_xfer;
  logic              w_last;
  logic              w_in_range0;
  logic              w_in_range1;

  // Oversized commands saturate so the write pointer never wraps into
  // entries of the same load.
  assign w_len_sat   = (cmd_len > LP_DEPTH) ? LP_DEPTH : cmd_len;
  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_xfer      = (r_state == S_LOAD) && in_valid;
  assign w_last      = ({1'b0, r_wptr} == (r_len - 1'b1));
  // The len bound is what hides stale entries left from earlier loads.
  assign w_in_range0 = ({1'b0, v_addr0} < r_len);
  assign w_in_range1 = ({1'b0, v_addr1} < r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    t3        = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // Held low while reset is asserted so no command is seen as taken.
        cmd_ready = ~rst;
        if (cmd_valid) begin
          w_next = (w_len_sat == '0) ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_last) begin
          w_next = S_START;
        end
      end
      S_START: begin
        t3     = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        if (kernel_done) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_wptr     <= '0;
      v_rd_data0 <= '0;
      v_rd_data1 <= '0;
    end else begin
      if (w_accept) begin
        r_len  <= w_len_sat;
        r_wptr <= '0;
      end else if (w_xfer) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (v_rd_en0) begin
        v_rd_data0 <= w_in_range0 ? r_bank0[v_addr0] : '0;
      end
      if (v_rd_en1) begin
        v_rd_data1 <= w_in_range1 ? r_bank1[v_addr1] : '0;
      end
    end
  end

  // Banks carry no reset; a same-edge read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_bank0[r_wptr] <= in_a;
      r_bank1[r_wptr] <= in_b;
    end
  end

`ifdef HIR_STAGER_RDCHK_EN
  logic r_rd_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_err <= 1'b0;
    end else if ((v_rd_en0 && !w_in_range0) || (v_rd_en1 && !w_in_range1)) begin
      r_rd_err <= 1'b1;
    end
  end

  assign rd_err = r_rd_err;
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_hir_input_stager.sv
// tb/tb_hir_input_stager.sv - scoreboard bench for hir_input_stager
module tb_hir_input_stager;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W:0]   cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              t3;
  logic              kernel_done;
  logic              busy;
  logic [ADDR_W-1:0] v_addr0;
  logic              v_rd_en0;
  logic [DATA_W-1:0] v_rd_data0;
  logic [ADDR_W-1:0] v_addr1;
  logic              v_rd_en1;
  logic [DATA_W-1:0] v_rd_data1;
  logic              rd_err;

  always #5 clk = ~clk;

  hir_input_stager #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .t3(t3), .kernel_done(kernel_done), .busy(busy),
    .v_addr0(v_addr0), .v_rd_en0(v_rd_en0), .v_rd_data0(v_rd_data0),
    .v_addr1(v_addr1), .v_rd_en1(v_rd_en1), .v_rd_data1(v_rd_data1),
    .rd_err(rd_err)
  );

  typedef struct {
    logic              cmd_ready;
    logic              in_ready;
    logic              t3;
    logic              busy;
    logic              err;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc_cnt  = 0;
  bit   g_rand_rd = 1'b0;

  // Reference model: phase 0 idle, 1 loading, 2 start pulse, 3 kernel running.
  int                m_phase = 0;
  int                m_len   = 0;
  int                m_cnt   = 0;
  logic [DATA_W-1:0] m_b0 [DEPTH];
  logic [DATA_W-1:0] m_b1 [DEPTH];
  logic [DATA_W-1:0] m_rd0 = '0;
  logic [DATA_W-1:0] m_rd1 = '0;
  bit                m_err = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, mon_e.cmd_ready});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, mon_e.in_ready});
      chk("t3",        {31'd0, t3},        {31'd0, mon_e.t3});
      chk("busy",      {31'd0, busy},      {31'd0, mon_e.busy});
      chk("rd_err",    {31'd0, rd_err},    {31'd0, mon_e.err});
      chk("rd_data0",  v_rd_data0, mon_e.rd0);
      chk("rd_data1",  v_rd_data1, mon_e.rd1);
    end
  end

  task automatic clear_inputs();
    cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
    kernel_done = 1'b0; v_rd_en0 = 1'b0; v_rd_en1 = 1'b0; v_addr0 = '0; v_addr1 = '0;
  endtask

  // One clock cycle: push what the model says the DUT shows now, advance the
  // model across the coming edge, then move to just after that edge.
  task automatic step_cycle();
    exp_t e;
    if (cyc_cnt > 50000) begin
      n_errs++;
      $display("FAIL cycle_budget: got %0d cycles expected under 50000", cyc_cnt);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $fatal(1);
    end
    if (g_rand_rd) begin
      v_rd_en0 = 1'($urandom_range(0, 1));
      v_rd_en1 = 1'($urandom_range(0, 1));
      v_addr0  = ADDR_W'($urandom_range(0, DEPTH - 1));
      v_addr1  = ADDR_W'($urandom_range(0, DEPTH - 1));
    end
    if (rst) begin
      m_phase = 0; m_len = 0; m_cnt = 0; m_rd0 = '0; m_rd1 = '0; m_err = 1'b0;
    end
    e.cmd_ready = !rst && (m_phase == 0);
    e.in_ready  = (m_phase == 1);
    e.t3        = (m_phase == 2);
    e.busy      = (m_phase != 0);
    e.err       = m_err;
    e.rd0       = m_rd0;
    e.rd1       = m_rd1;
    sb.push_back(e);
    if (!rst) begin
      if (v_rd_en0) begin
        m_rd0 = (int'(v_addr0) < m_len) ? m_b0[v_addr0] : '0;
`ifdef HIR_STAGER_RDCHK_EN
        if (int'(v_addr0) >= m_len) m_err = 1'b1;
`endif
      end
      if (v_rd_en1) begin
        m_rd1 = (int'(v_addr1) < m_len) ? m_b1[v_addr1] : '0;
`ifdef HIR_STAGER_RDCHK_EN
        if (int'(v_addr1) >= m_len) m_err = 1'b1;
`endif
      end
      case (m_phase)
        0: if (cmd_valid) begin
             m_len   = (int'(cmd_len) > DEPTH) ? DEPTH : int'(cmd_len);
             m_cnt   = 0;
             m_phase = (m_len > 0) ? 1 : 2;
           end
        1: if (in_valid) begin
             m_b0[m_cnt] = in_a;
             m_b1[m_cnt] = in_b;
             m_cnt++;
             if (m_cnt == m_len) m_phase = 2;
           end
        2: m_phase = 3;
        default: if (kernel_done) m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic run_cmd(input int len, input int vpct, input int done_dly);
    cmd_valid = 1'b1;
    cmd_len   = (ADDR_W+1)'(len);
    step_cycle();
    cmd_valid = 1'b0;
    while (m_phase == 1) begin
      in_valid    = ($urandom_range(0, 99) < vpct);
      in_a        = $urandom;
      in_b        = $urandom;
      kernel_done = ($urandom_range(0, 9) == 0);
      cmd_valid   = ($urandom_range(0, 9) == 0);
      cmd_len     = (ADDR_W+1)'($urandom_range(0, 255));
      step_cycle();
    end
    in_valid = 1'b0; kernel_done = 1'b0; cmd_valid = 1'b0;
    while (m_phase == 2) step_cycle();
    repeat (done_dly) step_cycle();
    kernel_done = 1'b1;
    step_cycle();
    kernel_done = 1'b0;
    step_cycle();
  endtask

  task automatic read_all(input int n);
    for (int i = 0; i < n; i++) begin
      v_rd_en0 = 1'b1; v_rd_en1 = 1'b1;
      v_addr0  = ADDR_W'(i);
      v_addr1  = ADDR_W'(n - 1 - i);
      step_cycle();
    end
    v_rd_en0 = 1'b0; v_rd_en1 = 1'b0;
    step_cycle();
  endtask

  initial begin
    int k;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step_cycle();
    rst = 1'b0;
    step_cycle();

    // Four back-to-back pairs, then targeted reads and the hold check.
    cmd_valid = 1'b1; cmd_len = 8'd4;
    step_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 32'(5 + i); in_b = 32'(100 + i);
      step_cycle();
    end
    in_valid = 1'b0;
    step_cycle();
    step_cycle();
    v_rd_en0 = 1'b1; v_addr0 = 7'd2;
    step_cycle();
    v_rd_en0 = 1'b0;
    step_cycle();
    step_cycle();
    v_rd_en1 = 1'b1; v_addr1 = 7'd3;
    step_cycle();
    v_rd_en1 = 1'b0;
    step_cycle();
    kernel_done = 1'b1;
    step_cycle();
    kernel_done = 1'b0;
    step_cycle();

    // in_valid toggling: only handshake cycles write, no gaps.
    cmd_valid = 1'b1; cmd_len = 8'd4;
    step_cycle();
    cmd_valid = 1'b0;
    k = 0;
    while (m_phase == 1) begin
      in_valid = (k % 2 == 0);
      in_a = 32'(20 + k); in_b = 32'(200 + k);
      k++;
      step_cycle();
    end
    in_valid = 1'b0;
    run_cmd(-1 + 1, 100, 2);
    cmd_valid = 1'b1; cmd_len = 8'd4;
    step_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 32'(40 + i); in_b = 32'(400 + i);
      step_cycle();
    end
    in_valid = 1'b0;
    step_cycle();
    kernel_done = 1'b1;
    step_cycle();
    kernel_done = 1'b0;
    read_all(4);

    // Saturating length, then full-depth readback.
    run_cmd(200, 100, 1);
    read_all(DEPTH);

    // Out-of-range read with len 4.
    run_cmd(4, 100, 0);
    v_rd_en0 = 1'b1; v_addr0 = 7'd10;
    step_cycle();
    v_rd_en0 = 1'b0;
    repeat (3) step_cycle();

    // Reset after two of four pairs, then a normal load.
    cmd_valid = 1'b1; cmd_len = 8'd4;
    step_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 32'(60 + i); in_b = 32'(600 + i);
      step_cycle();
    end
    rst = 1'b1;
    step_cycle();
    step_cycle();
    clear_inputs();
    rst = 1'b0;
    step_cycle();
    step_cycle();
    run_cmd(4, 100, 1);
    read_all(4);

    // Randomized loads with random reads in every state.
    g_rand_rd = 1'b1;
    for (int t = 0; t < 25; t++) begin
      run_cmd($urandom_range(0, 150), $urandom_range(30, 100), $urandom_range(0, 5));
      repeat ($urandom_range(0, 3)) step_cycle();
    end
    g_rand_rd = 1'b0;
    clear_inputs();
    step_cycle();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
